// File: rtl/mat_feed_buffer.sv
// Operand store and diagonal-skew feeder for a 2x2 systolic MMU.
// Optional macro WM_WRITE_GUARD_EN: reject host writes while a feed is running or starting.
module mat_feed_buffer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] host_data,
    input  logic              wm_load_mat,
    input  logic [2:0]        wm_addr,
    input  logic              feeding_en,
    output logic [DATA_W-1:0] a_in0,
    output logic [DATA_W-1:0] a_in1,
    output logic [DATA_W-1:0] b_in0,
    output logic [DATA_W-1:0] b_in1,
    output logic              feed_valid,
    output logic              busy,
    output logic              mats_ready,
    output logic              feed_done,
    output logic              wr_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FEED = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [DATA_W-1:0] ZERO_W = {DATA_W{1'b0}};

    state_e            state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic              fe_q;
    logic [DATA_W-1:0] mem_q [8];
    logic [7:0]        loaded_q, loaded_d;
    logic [DATA_W-1:0] a0_q, a1_q, b0_q, b1_q;
    logic [DATA_W-1:0] a0_d, a1_d, b0_d, b1_d;
    logic              fv_q, fv_d;
    logic              busy_q, busy_d;
    logic              mr_q, mr_d;
    logic              fd_q, fd_d;

    logic              start_s;
    logic              wr_block_s;
    logic              wr_commit_s;
    logic              ld_en_s;
    logic [1:0]        ld_phase_s;
    logic              clear_s;

    // Edge detect on the feed command and write acceptance.
    always_comb begin
        start_s = feeding_en & ~fe_q;
`ifdef WM_WRITE_GUARD_EN
        wr_block_s = (state_q != ST_IDLE) | start_s;
`else
        wr_block_s = 1'b0;
`endif
        wr_commit_s = wm_load_mat & ~wr_block_s;
    end

`ifdef WM_WRITE_GUARD_EN
    assign wr_err = wm_load_mat & wr_block_s;
`else
    assign wr_err = 1'b0;
`endif

    // Next-state logic: sequence IDLE -> FEED(p0,p1,p2) -> DONE -> IDLE.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        ld_en_s    = 1'b0;
        ld_phase_s = 2'd0;
        clear_s    = 1'b0;
        fd_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d    = ST_FEED;
                    phase_d    = 2'd0;
                    ld_en_s    = 1'b1;
                    ld_phase_s = 2'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FEED: begin
                if (phase_q == 2'd2) begin
                    state_d = ST_DONE;
                    phase_d = 2'd0;
                    fd_d    = 1'b1;
                end else begin
                    phase_d    = phase_q + 2'd1;
                    ld_en_s    = 1'b1;
                    ld_phase_s = phase_q + 2'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                clear_s = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = 2'd0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        fv_d   = (state_d == ST_FEED);
    end

    // Skewed operand selection: row i / column j is delayed by i / j cycles.
    always_comb begin
        a0_d = ZERO_W;
        a1_d = ZERO_W;
        b0_d = ZERO_W;
        b1_d = ZERO_W;
        if (ld_en_s) begin
            case (ld_phase_s)
                2'd0: begin
                    a0_d = mem_q[0];
                    b0_d = mem_q[4];
                end
                2'd1: begin
                    a0_d = mem_q[1];
                    a1_d = mem_q[2];
                    b0_d = mem_q[6];
                    b1_d = mem_q[5];
                end
                2'd2: begin
                    a1_d = mem_q[3];
                    b1_d = mem_q[7];
                end
                default: begin
                    a0_d = ZERO_W;
                end
            endcase
        end else begin
            a0_d = ZERO_W;
        end
    end

    // Loaded bitmap: cleared on exit from DONE, then any write that cycle re-marks its slot.
    always_comb begin
        loaded_d = loaded_q;
        if (clear_s) begin
            loaded_d = 8'd0;
        end else begin
            loaded_d = loaded_q;
        end
        if (wr_commit_s) begin
            loaded_d[wm_addr] = 1'b1;
        end else begin
            loaded_d = loaded_d;
        end
        mr_d = &loaded_d;
    end

    // Operand storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[i] <= ZERO_W;
            end
        end else if (wr_commit_s) begin
            mem_q[wm_addr] <= host_data;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            phase_q  <= 2'd0;
            fe_q     <= 1'b0;
            loaded_q <= 8'd0;
            a0_q     <= ZERO_W;
            a1_q     <= ZERO_W;
            b0_q     <= ZERO_W;
            b1_q     <= ZERO_W;
            fv_q     <= 1'b0;
            busy_q   <= 1'b0;
            mr_q     <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            fe_q     <= feeding_en;
            loaded_q <= loaded_d;
            a0_q     <= a0_d;
            a1_q     <= a1_d;
            b0_q     <= b0_d;
            b1_q     <= b1_d;
            fv_q     <= fv_d;
            busy_q   <= busy_d;
            mr_q     <= mr_d;
            fd_q     <= fd_d;
        end
    end

    assign a_in0      = a0_q;
    assign a_in1      = a1_q;
    assign b_in0      = b0_q;
    assign b_in1      = b1_q;
    assign feed_valid = fv_q;
    assign busy       = busy_q;
    assign mats_ready = mr_q;
    assign feed_done  = fd_q;

endmodule

// File: tb/tb_mat_feed_buffer.sv
// Self-checking bench for mat_feed_buffer: directed scenarios plus random traffic
// compared every cycle against a behavioural skew/storage model.
module tb_mat_feed_buffer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] host_data;
    logic       wm_load_mat;
    logic [2:0] wm_addr;
    logic       feeding_en;
    logic [7:0] a_in0, a_in1, b_in0, b_in1;
    logic       feed_valid, busy, mats_ready, feed_done, wr_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: matrices, written flags, cycles since start (0 = idle).
    logic [7:0] m_a [2][2];
    logic [7:0] m_b [2][2];
    bit         m_written [8];
    int         m_t;
    logic       m_fe_prev;
    logic [7:0] e_a0, e_a1, e_b0, e_b1;
    logic       e_fv, e_busy, e_mr, e_fd, e_we;

    mat_feed_buffer #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host_data  (host_data),
        .wm_load_mat(wm_load_mat),
        .wm_addr    (wm_addr),
        .feeding_en (feeding_en),
        .a_in0      (a_in0),
        .a_in1      (a_in1),
        .b_in0      (b_in0),
        .b_in1      (b_in1),
        .feed_valid (feed_valid),
        .busy       (busy),
        .mats_ready (mats_ready),
        .feed_done  (feed_done),
        .wr_err     (wr_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                m_a[i][j] = 8'd0;
                m_b[i][j] = 8'd0;
            end
        end
        for (int k = 0; k < 8; k++) m_written[k] = 1'b0;
        m_t = 0; m_fe_prev = 1'b0;
        e_a0 = 8'd0; e_a1 = 8'd0; e_b0 = 8'd0; e_b1 = 8'd0;
        e_fv = 1'b0; e_busy = 1'b0; e_mr = 1'b0; e_fd = 1'b0; e_we = 1'b0;
    endtask

    // One clock edge of the model: row i / column j sees element k = p - i / p - j at phase p.
    task automatic model_edge();
        bit start, wr_ok, all;
        int nt, p;
        start = feeding_en && !m_fe_prev;
        if (m_t == 0) nt = start ? 1 : 0;
        else if (m_t < 4) nt = m_t + 1;
        else nt = 0;
        e_a0 = 8'd0; e_a1 = 8'd0; e_b0 = 8'd0; e_b1 = 8'd0;
        if (nt >= 1 && nt <= 3) begin
            p = nt - 1;
            if (p <= 1) e_a0 = m_a[0][p];
            if (p >= 1) e_a1 = m_a[1][p-1];
            if (p <= 1) e_b0 = m_b[p][0];
            if (p >= 1) e_b1 = m_b[p-1][1];
        end
        e_fv   = (nt >= 1 && nt <= 3);
        e_busy = (nt != 0);
        e_fd   = (nt == 4);
        wr_ok  = wm_load_mat;
`ifdef WM_WRITE_GUARD_EN
        if (m_t != 0 || start) wr_ok = 1'b0;
        e_we = wm_load_mat && (nt != 0);
`else
        e_we = 1'b0;
`endif
        if (m_t == 4) for (int k = 0; k < 8; k++) m_written[k] = 1'b0;
        if (wr_ok) begin
            if (wm_addr < 3'd4) m_a[wm_addr[1]][wm_addr[0]] = host_data;
            else                m_b[wm_addr[1]][wm_addr[0]] = host_data;
            m_written[wm_addr] = 1'b1;
        end
        all = 1'b1;
        for (int k = 0; k < 8; k++) if (!m_written[k]) all = 1'b0;
        e_mr = all;
        m_fe_prev = feeding_en;
        m_t = nt;
    endtask

    task automatic compare_all();
        check_eq("a_in0", 32'(a_in0), 32'(e_a0));
        check_eq("a_in1", 32'(a_in1), 32'(e_a1));
        check_eq("b_in0", 32'(b_in0), 32'(e_b0));
        check_eq("b_in1", 32'(b_in1), 32'(e_b1));
        check_eq("feed_valid", 32'(feed_valid), 32'(e_fv));
        check_eq("busy", 32'(busy), 32'(e_busy));
        check_eq("mats_ready", 32'(mats_ready), 32'(e_mr));
        check_eq("feed_done", 32'(feed_done), 32'(e_fd));
        check_eq("wr_err", 32'(wr_err), 32'(e_we));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic check_ops(input string tag, input logic [31:0] exp);
        check_eq(tag, {a_in0, a_in1, b_in0, b_in1}, exp);
    endtask

    initial begin
        rst_n = 1'b0; host_data = 8'd0; wm_load_mat = 1'b0; wm_addr = 3'd0; feeding_en = 1'b0;
        model_reset();
        #12;
        compare_all();
        check_ops("reset_ops", 32'h0000_0000);
        rst_n = 1'b1;

        // Fill A={1,2,3,4}, B={5,6,7,8}.
        for (int i = 0; i < 8; i++) begin
            wm_load_mat = 1'b1; wm_addr = 3'(i); host_data = 8'(i + 1);
            step();
            if (i == 6) check_eq("mr_before_last", 32'(mats_ready), 32'd0);
        end
        wm_load_mat = 1'b0;
        check_eq("mr_after_last", 32'(mats_ready), 32'd1);

        // Skew sequence with feeding_en held high.
        feeding_en = 1'b1;
        step(); check_ops("p0", 32'h0100_0500);
        step(); check_ops("p1", 32'h0203_0706);
        step(); check_ops("p2", 32'h0004_0008);
        step(); check_eq("done_pulse", {29'd0, feed_done, busy, feed_valid}, 32'd6);
        step(); check_eq("idle_after", {29'd0, feed_done, busy, mats_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(); check_eq("no_retrigger", 32'(busy), 32'd0);
        end

        // Re-raise during busy is ignored; re-raise after idle replays retained data.
        feeding_en = 1'b0; step();
        feeding_en = 1'b1; step();
        feeding_en = 1'b0; step();
        feeding_en = 1'b1; step();
        step(); step(); step(); step();
        check_eq("busy_ignored_restart", 32'(busy), 32'd0);
        feeding_en = 1'b0; step();
        feeding_en = 1'b1; step();
        check_ops("replay_p0", 32'h0100_0500);
        step(); step(); step(); step();

        // Write a11 during p0.
        feeding_en = 1'b0; step();
        feeding_en = 1'b1; step();
        wm_load_mat = 1'b1; wm_addr = 3'd3; host_data = 8'h99;
        step();
        wm_load_mat = 1'b0;
        step();
`ifdef WM_WRITE_GUARD_EN
        check_eq("midfeed_a11", 32'(a_in1), 32'h04);
`else
        check_eq("midfeed_a11", 32'(a_in1), 32'h99);
`endif
        step(); step();

        // Asynchronous abort during p1.
        feeding_en = 1'b0; step();
        feeding_en = 1'b1; step(); step();
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_outs", {a_in0, a_in1, b_in0, b_in1}, 32'd0);
        check_eq("abort_ctl", {27'd0, feed_valid, busy, mats_ready, feed_done, wr_err}, 32'd0);
        model_reset();
        compare_all();
        feeding_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_eq("post_abort_mr", 32'(mats_ready), 32'd0);
        feeding_en = 1'b1;
        step(); check_eq("zero_feed_valid", 32'(feed_valid), 32'd1);
        check_ops("zero_feed_p0", 32'd0);
        step(); step(); step();
        check_eq("zero_feed_done", 32'(feed_done), 32'd1);
        step();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            wm_load_mat = ($urandom_range(0, 2) == 0);
            wm_addr     = 3'($urandom_range(0, 7));
            host_data   = 8'($urandom);
            if ($urandom_range(0, 5) == 0) feeding_en = ~feeding_en;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
